// File: rtl/mips16_pkg.sv
// Shared mips16 datapath types: data width, demux destination encoding and
// the per-channel buffer occupancy used by the write-back demultiplexer.
package mips16_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        DST_A = 1'b0,
        DST_B = 1'b1
    } demux_dst_e;

    // Encoded value equals the number of beats held (main + skid).
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic occ_can_accept(input occ_e occ);
        return (occ != OCC_FULL);
    endfunction

endpackage

// File: rtl/demux1_2_skid_if.sv
// Handshake bundle of the 1:2 demux: one input stream, two output channels,
// busy flag and per-channel occupancy for observation.
interface demux1_2_skid_if
    import mips16_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    // Valid/ready rule on every stream: a beat transfers on a rising clock
    // edge where valid & ready; once valid is raised it stays high with
    // stable payload (and in_sel) until that transfer happens.
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;

    logic             outa_valid;
    logic             outa_ready;
    logic [WIDTH-1:0] outa_data;

    logic             outb_valid;
    logic             outb_ready;
    logic [WIDTH-1:0] outb_data;

    logic             busy;
    occ_e             occ_a;
    occ_e             occ_b;

    modport master (
        output in_valid, in_sel, in_data, outa_ready, outb_ready,
        input  in_ready, outa_valid, outa_data, outb_valid, outb_data,
        input  busy, occ_a, occ_b
    );

    modport slave (
        input  in_valid, in_sel, in_data, outa_ready, outb_ready,
        output in_ready, outa_valid, outa_data, outb_valid, outb_data,
        output busy, occ_a, occ_b
    );

endinterface

// File: rtl/skid_buf.sv
// One output channel: 2-entry (main + skid) buffer. in_ready depends only on
// registered occupancy, so downstream ready never reaches the input path.
module skid_buf
    import mips16_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output occ_e             occ
);

    occ_e             state_q;
    occ_e             state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             acc;
    logic             drn;
    logic             load_main;
    logic             load_skid;
    logic             pop_skid;

    assign in_ready  = occ_can_accept(state_q);
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign occ       = state_q;

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        unique case (state_q)
            OCC_EMPTY: begin
                if (acc) begin
                    state_d   = OCC_ONE;
                    load_main = 1'b1;
                end
            end
            OCC_ONE: begin
                // Accept with drain is a pass-through: main is replaced, skid unused.
                if (acc && drn) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    state_d   = OCC_FULL;
                    load_skid = 1'b1;
                end else if (drn) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (drn) begin
                    state_d  = OCC_ONE;
                    pop_skid = 1'b1;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
    end

    // main_q keeps its last value when the channel empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    a_out_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data)
    );

endmodule

// File: rtl/demux1_2_skid.sv
// 1:2 streaming demux: routes each input beat to channel A or B by in_sel,
// each channel buffered by its own skid_buf.
module demux1_2_skid
    import mips16_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    demux1_2_skid_if.slave  bus
);

    demux_dst_e dst;
    logic       rdy_a;
    logic       rdy_b;
    logic       acc_a;
    logic       acc_b;

    assign dst = demux_dst_e'(bus.in_sel);

    // A full channel only blocks beats addressed to it.
    assign bus.in_ready = (dst == DST_B) ? rdy_b : rdy_a;

    assign acc_a = bus.in_valid & bus.in_ready & (dst == DST_A);
    assign acc_b = bus.in_valid & bus.in_ready & (dst == DST_B);

    assign bus.busy = bus.outa_valid | bus.outb_valid;

    skid_buf #(
        .WIDTH (WIDTH)
    ) u_chan_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (acc_a),
        .in_ready  (rdy_a),
        .in_data   (bus.in_data),
        .out_valid (bus.outa_valid),
        .out_ready (bus.outa_ready),
        .out_data  (bus.outa_data),
        .occ       (bus.occ_a)
    );

    skid_buf #(
        .WIDTH (WIDTH)
    ) u_chan_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (acc_b),
        .in_ready  (rdy_b),
        .in_data   (bus.in_data),
        .out_valid (bus.outb_valid),
        .out_ready (bus.outb_ready),
        .out_data  (bus.outb_data),
        .occ       (bus.occ_b)
    );

    a_in_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.in_valid && !bus.in_ready |=>
            bus.in_valid && $stable(bus.in_sel) && $stable(bus.in_data)
    );

endmodule

// File: tb/tb_demux1_2_skid.sv
// Bench for demux1_2_skid: directed scenarios plus random traffic, checked
// against two bounded FIFOs (capacity 2) that model the channels.
module tb_demux1_2_skid;
    import mips16_pkg::*;

    localparam int W = DATA_W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux1_2_skid_if #(.WIDTH(W)) bus ();

    demux1_2_skid #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    int           total = 0;
    int           bad = 0;
    logic         acc_seen = 1'b0;
    logic         stall_a = 1'b0;
    logic         stall_b = 1'b0;
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic         rand_rdy = 1'b0;
    logic         mod_rdy;
    logic         mod_acc;
    logic         drn_a;
    logic         drn_b;
    int           cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard / monitor: compares DUT against the FIFO model, then advances it.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_outa_valid", bus.outa_valid, 0);
            check("rst_outb_valid", bus.outb_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_in_ready", bus.in_ready, 1);
            check("rst_outa_data", bus.outa_data, 0);
            check("rst_outb_data", bus.outb_data, 0);
            exp_a.delete();
            exp_b.delete();
            stall_a  = 1'b0;
            stall_b  = 1'b0;
            acc_seen = 1'b0;
        end else begin
            mod_rdy = bus.in_sel ? (exp_b.size() < 2) : (exp_a.size() < 2);
            check("in_ready", bus.in_ready, mod_rdy);
            check("outa_valid", bus.outa_valid, exp_a.size() > 0);
            check("outb_valid", bus.outb_valid, exp_b.size() > 0);
            check("occ_a", bus.occ_a, exp_a.size());
            check("occ_b", bus.occ_b, exp_b.size());
            check("busy", bus.busy, (exp_a.size() + exp_b.size()) > 0);
            if (stall_a) check("outa_hold", bus.outa_data, last_a);
            if (stall_b) check("outb_hold", bus.outb_data, last_b);
            if (exp_a.size() > 0) check("outa_data", bus.outa_data, exp_a[0]);
            if (exp_b.size() > 0) check("outb_data", bus.outb_data, exp_b[0]);
            drn_a   = (exp_a.size() > 0) && bus.outa_ready;
            drn_b   = (exp_b.size() > 0) && bus.outb_ready;
            stall_a = (exp_a.size() > 0) && !bus.outa_ready;
            stall_b = (exp_b.size() > 0) && !bus.outb_ready;
            last_a  = bus.outa_data;
            last_b  = bus.outb_data;
            if (drn_a) void'(exp_a.pop_front());
            if (drn_b) void'(exp_b.pop_front());
            mod_acc = bus.in_valid && mod_rdy;
            if (mod_acc) begin
                if (bus.in_sel) exp_b.push_back(bus.in_data);
                else            exp_a.push_back(bus.in_data);
            end
            acc_seen = mod_acc;
        end
    end

    // Random consumer backpressure, active only while rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                bus.outa_ready = 1'($urandom_range(0, 1));
                bus.outb_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic sel, input logic [W-1:0] d, output int n);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_seen && n < 200);
        if (!acc_seen) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept of %h at %0t", d, $time);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while ((exp_a.size() + exp_b.size()) > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", (exp_a.size() + exp_b.size()), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_sel     = 1'b0;
        bus.in_data    = 16'h1234;
        bus.outa_ready = 1'b1;
        bus.outb_ready = 1'b1;

        // Reset held with a pending beat; first beat after release lands on A.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b0, 16'h1234, cyc);
        check("t1_first_accept", cyc, 1);
        idle(2);

        // Alternating A/B with both consumers ready: one beat per cycle.
        send(1'b0, 16'h0001, cyc); check("t2_beat1", cyc, 1);
        send(1'b1, 16'h0002, cyc); check("t2_beat2", cyc, 1);
        send(1'b0, 16'h0003, cyc); check("t2_beat3", cyc, 1);
        send(1'b1, 16'h0004, cyc); check("t2_beat4", cyc, 1);
        idle(2);

        // A stalled and filled to two; B keeps flowing.
        bus.outa_ready = 1'b0;
        send(1'b0, 16'hAAAA, cyc); check("t3_a_first", cyc, 1);
        send(1'b0, 16'hBBBB, cyc); check("t3_a_second", cyc, 1);
        send(1'b1, 16'hCCCC, cyc); check("t3_b_flows", cyc, 1);
        bus.in_sel = 1'b0;
        idle(2);
        check("t3_a_blocked", bus.in_ready, 0);
        bus.outa_ready = 1'b1;
        wait_empty();
        idle(1);

        // Pass-through at occupancy 1.
        send(1'b0, 16'h0010, cyc); check("t4_beat0", cyc, 1);
        send(1'b0, 16'h0011, cyc); check("t4_beat1", cyc, 1);
        send(1'b0, 16'h0012, cyc); check("t4_beat2", cyc, 1);
        idle(3);

        // Async reset with A full: held beats are discarded.
        bus.outa_ready = 1'b0;
        send(1'b0, 16'hAAAA, cyc);
        send(1'b0, 16'hBBBB, cyc);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", bus.outa_valid, 0);
        check("t5_async_busy", bus.busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.outa_ready = 1'b1;
        idle(4);

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(1'($urandom_range(0, 1)), W'($urandom), cyc);
        end
        bus.in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.outa_ready = 1'b1;
        bus.outb_ready = 1'b1;
        wait_empty();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1_2_skid.md
Name: demux1_2_skid

Overview:
- 1-to-2 streaming demultiplexer: the write-side counterpart of the 2:1 selector. It steers one valid/ready input stream to one of two output channels, chosen per beat by `in_sel`.
- Each output channel has a 2-entry skid buffer (main + skid), so output-side backpressure never reaches `in_ready` combinationally through `out*_ready`.
- Used in the mips16 datapath to route write-back/result beats (e.g. regfile vs. memory/store path).

Parameters:
- WIDTH, 16, data width of input and both output channels.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_sel  input  1  destination: 0 = channel A, 1 = channel B; sampled with the beat.
- in_data  input  WIDTH  input payload.
- outa_valid  output  1  channel A beat present.
- outa_ready  input  1  channel A consumer ready.
- outa_data  output  WIDTH  channel A payload.
- outb_valid  output  1  channel B beat present.
- outb_ready  input  1  channel B consumer ready.
- outb_data  output  WIDTH  channel B payload.
- busy  output  1  any beat held in either channel.

Behaviour:
- Reset (rst_n low, async): all main_v/skid_v cleared. outa_valid = outb_valid = 0, busy = 0, outa_data = outb_data = 0. in_ready is not forced: it equals ~skid_v[in_sel], which is 1 after reset. Any beats held mid-operation are discarded, not flushed.
- Per channel c ∈ {A,B}, state = (main_v, main_d, skid_v, skid_d). Occupancy is 0, 1 or 2, and skid_v implies main_v.
- in_ready = ~skid_v[in_sel]. It depends only on registered state and in_sel, never on out*_ready.
- Accept: acc_c = in_valid & in_ready & (in_sel == c).
- Drain: drn_c = main_v_c & out_ready_c.
- Channel update at the clock edge:
  - Occupancy 0, acc: main ← in_data.
  - Occupancy 1:
    - acc & drn: main ← in_data (pass-through, occupancy stays 1).
    - acc & ~drn: skid ← in_data (occupancy 2).
    - drn only: main cleared.
  - Occupancy 2 (acc impossible):
    - drn: main ← skid, skid cleared.
    - no drn: hold.
- Latency: an accepted beat is visible on out*_valid/out*_data exactly 1 cycle later.
- Throughput: with the consumer always ready, one beat per cycle to either channel, in any interleaving.
- out*_valid = main_v_c and out*_data = main_d_c, both registered.
- When main_v = 0, out*_data holds its last value; it is not cleared.
- Ordering: per-channel FIFO order is preserved. No ordering guarantee across channels.
- Channels are independent: a full channel A (occupancy 2) blocks only beats with in_sel = 0. Beats to B still flow.
- in_sel and in_data must be stable while in_valid & ~in_ready. A valid beat is never withdrawn (AXI-style rule, checked by assertion).
- busy = main_v_A | main_v_B.
- Outputs hold valid/data stable while valid & ~ready (assertion).

Decomposition:
- Shared package mips16_pkg holds `localparam int DATA_W = 16` and `typedef enum logic {DST_A = 1'b0, DST_B = 1'b1} demux_dst_e`.
- Natural sub-module: skid_buf (one channel: in valid/ready/data → 2-entry buffer → out valid/ready/data, with async active-low reset). It is instantiated twice.
- Top level contains only the accept/route logic and the in_ready select.

Test Plan:
1. Reset with in_valid = 1, in_sel = 0, in_data = 16'h1234, rst_n low 3 cycles → outa_valid = outb_valid = 0, busy = 0, in_ready = 1. First beat after release appears on A one cycle later.
2. Both consumers ready, beats 0x0001(A), 0x0002(B), 0x0003(A), 0x0004(B) on consecutive cycles → in_ready constant 1. Each beat appears on its channel 1 cycle after accept. Total 4 cycles, no bubbles.
3. outa_ready = 0, send 0xAAAA(A), 0xBBBB(A) → occupancy A = 2 and in_ready = 0 for in_sel = 0. Meanwhile 0xCCCC(B) is accepted and output on B. Raise outa_ready → 0xAAAA then 0xBBBB on consecutive cycles, and in_ready returns to 1 the cycle after the first drain.
4. Simultaneous accept and drain on A at occupancy 1 (outa_ready = 1, stream 0x10, 0x11, 0x12 to A) → occupancy stays 1, outputs 0x10, 0x11, 0x12 in order, no skid use.
5. Channel A full (occupancy 2), assert rst_n low mid-cycle → outa_valid drops immediately (async), busy = 0. After release no stale 0xAAAA/0xBBBB beat is emitted.
6. Random interleaving of 1000 beats with random out*_ready (50%) → scoreboard: per-channel order and data match, no loss or duplication, valid/data stable while stalled.
